// File: rtl/cei_mochila_pkg.sv
// Shared types and helpers for the safe-CPU hart run sequencer.
package cei_mochila_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET,
        BOOT,
        RUN,
        DONE
    } hart_seq_state_e;

    localparam logic [1:0] SAFE_CFG_TMR = 2'b00;
    localparam logic [1:0] SAFE_CFG_DMR = 2'b01;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Reserved safe configurations fall back to full TMR; a malformed master selects hart 0.
    function automatic logic [2:0] active_mask(input logic       safe_mode,
                                               input logic [1:0] cfg,
                                               input logic [2:0] master);
        if (safe_mode) begin
            return (cfg == SAFE_CFG_DMR) ? 3'b011 : 3'b111;
        end
        return is_onehot3(master) ? master : 3'b001;
    endfunction

endpackage

// File: rtl/cb_sleep_filter.sv
// Saturating consecutive-cycle counter; done flags the cycle whose edge completes the run.
module cb_sleep_filter #(
    parameter int SLEEP_FILTER = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr,
    input  logic cond,
    output logic done
);

    localparam int CNT_W = $clog2(SLEEP_FILTER + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr || !cond) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(SLEEP_FILTER)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Looks one edge ahead so the state register reaches DONE as the count reaches SLEEP_FILTER.
    assign done = cond && !clr && (cnt_q >= CNT_W'(SLEEP_FILTER - 1));

endmodule

// File: rtl/cb_hart_sequencer.sv
// Boots the selected harts from the control-register configuration and reports end-of-routine.
module cb_hart_sequencer
    import cei_mochila_pkg::*;
#(
    parameter int NHARTS          = 3,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int SLEEP_FILTER    = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [31:0]       boot_addr_i,
    input  logic [2:0]        master_core_i,
    input  logic              safe_mode_i,
    input  logic [1:0]        safe_configuration_i,
    input  logic              critical_section_i,
    input  logic [NHARTS-1:0] sleep_i,
    input  logic [NHARTS-1:0] debug_mode_i,
    output logic [NHARTS-1:0] hart_rst_no,
    output logic [NHARTS-1:0] fetch_enable_o,
    output logic [31:0]       hart_boot_addr_o,
    output logic [NHARTS-1:0] active_mask_o,
    output logic              end_sw_o,
    output logic              busy_o,
    output logic              cfg_err_o
);

    localparam int HOLD_W = $clog2(RST_HOLD_CYCLES + 1);

    hart_seq_state_e   state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_q;
    logic [NHARTS-1:0] mask_q;
    logic [31:0]       boot_addr_q;
    logic              cfg_err_q;
    logic              launch;
    logic              do_launch;
    logic              asleep;
    logic              filter_done;
    logic [2:0]        mask_d;

    assign launch    = start_i && !start_q;
    assign do_launch = launch && ((state_q == IDLE) || (state_q == DONE));
    assign mask_d    = active_mask(safe_mode_i, safe_configuration_i, master_core_i);

    assign asleep = ((sleep_i & mask_q) == mask_q)
                 && ((debug_mode_i & mask_q) == '0)
                 && !critical_section_i;

    cb_sleep_filter #(
        .SLEEP_FILTER (SLEEP_FILTER)
    ) u_sleep_filter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr    (state_q != RUN),
        .cond   (asleep),
        .done   (filter_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            start_q     <= 1'b0;
            mask_q      <= '0;
            boot_addr_q <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            start_q <= start_i;
            if (do_launch) begin
                mask_q      <= mask_d;
                boot_addr_q <= boot_addr_i;
                cfg_err_q   <= !safe_mode_i && !is_onehot3(master_core_i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RESET;
                    hold_d  = HOLD_W'(RST_HOLD_CYCLES - 1);
                end
            end
            RESET: begin
                if (hold_q == '0) begin
                    state_d = BOOT;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            BOOT: state_d = RUN;
            RUN: begin
                // A software abort wins over a completion landing on the same cycle.
                if (!start_i) begin
                    state_d = IDLE;
                end else if (filter_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (launch) begin
                    state_d = RESET;
                    hold_d  = HOLD_W'(RST_HOLD_CYCLES - 1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hart_rst_no      = (state_q inside {BOOT, RUN, DONE}) ? mask_q : '0;
    assign fetch_enable_o   = (state_q inside {RUN, DONE}) ? mask_q : '0;
    assign end_sw_o         = (state_q == DONE);
    assign busy_o           = (state_q inside {RESET, BOOT, RUN});
    assign hart_boot_addr_o = boot_addr_q;
    assign active_mask_o    = mask_q;
    assign cfg_err_o        = cfg_err_q;

endmodule

// File: tb/tb_cb_hart_sequencer.sv
// Scoreboard bench for cb_hart_sequencer: expected output snapshots are queued per cycle.
module tb_cb_hart_sequencer;

    localparam int ST_IDLE  = 0;
    localparam int ST_RESET = 1;
    localparam int ST_BOOT  = 2;
    localparam int ST_RUN   = 3;
    localparam int ST_DONE  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] boot_addr;
    logic [2:0]  master_core;
    logic        safe_mode;
    logic [1:0]  safe_cfg;
    logic        crit;
    logic [2:0]  sleep;
    logic [2:0]  dbg;
    logic [2:0]  hart_rst_n;
    logic [2:0]  fetch_en;
    logic [31:0] hart_boot_addr;
    logic [2:0]  act_mask;
    logic        end_sw;
    logic        busy;
    logic        cfg_err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [2:0]  rst_n;
        logic [2:0]  fe;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic        end_sw;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic        sm;
        logic [1:0]  cfg;
        logic [2:0]  master;
        logic [2:0]  exp_mask;
        logic        exp_err;
    } mask_vec_t;

    typedef struct {
        int off;
        int st;
    } seq_vec_t;

    cb_hart_sequencer dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .start_i              (start),
        .boot_addr_i          (boot_addr),
        .master_core_i        (master_core),
        .safe_mode_i          (safe_mode),
        .safe_configuration_i (safe_cfg),
        .critical_section_i   (crit),
        .sleep_i              (sleep),
        .debug_mode_i         (dbg),
        .hart_rst_no          (hart_rst_n),
        .fetch_enable_o       (fetch_en),
        .hart_boot_addr_o     (hart_boot_addr),
        .active_mask_o        (act_mask),
        .end_sw_o             (end_sw),
        .busy_o               (busy),
        .cfg_err_o            (cfg_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outputs for a state, from the per-state output table of the sequencer.
    task automatic push_st(input int c, input string tag, input int st,
                           input logic [2:0] m, input logic [31:0] a, input logic e);
        exp_t x;
        x.cyc    = c;
        x.tag    = tag;
        x.mask   = m;
        x.addr   = a;
        x.err    = e;
        x.rst_n  = (st == ST_BOOT || st == ST_RUN || st == ST_DONE) ? m : 3'b000;
        x.fe     = (st == ST_RUN || st == ST_DONE) ? m : 3'b000;
        x.end_sw = (st == ST_DONE);
        x.busy   = (st == ST_RESET || st == ST_BOOT || st == ST_RUN);
        sb.push_back(x);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                if (hart_rst_n !== sb[i].rst_n || fetch_en !== sb[i].fe ||
                    act_mask !== sb[i].mask || hart_boot_addr !== sb[i].addr ||
                    end_sw !== sb[i].end_sw || busy !== sb[i].busy || cfg_err !== sb[i].err) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got rst_n=%b fe=%b mask=%b addr=%h end=%b busy=%b err=%b want rst_n=%b fe=%b mask=%b addr=%h end=%b busy=%b err=%b",
                             sb[i].tag, cyc, hart_rst_n, fetch_en, act_mask, hart_boot_addr,
                             end_sw, busy, cfg_err, sb[i].rst_n, sb[i].fe, sb[i].mask,
                             sb[i].addr, sb[i].end_sw, sb[i].busy, sb[i].err);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s never sampled got cyc=%0d want cyc=%0d", sb[i].tag, cyc, sb[i].cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got time=%0t want finish before it", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        mask_vec_t mvec[9];
        seq_vec_t  svec[6];
        int c;
        logic [31:0] a;

        mvec[0] = '{1'b1, 2'b00, 3'b000, 3'b111, 1'b0};
        mvec[1] = '{1'b1, 2'b01, 3'b000, 3'b011, 1'b0};
        mvec[2] = '{1'b1, 2'b10, 3'b000, 3'b111, 1'b0};
        mvec[3] = '{1'b1, 2'b11, 3'b100, 3'b111, 1'b0};
        mvec[4] = '{1'b0, 2'b01, 3'b101, 3'b001, 1'b1};
        mvec[5] = '{1'b0, 2'b00, 3'b010, 3'b010, 1'b0};
        mvec[6] = '{1'b0, 2'b00, 3'b000, 3'b001, 1'b1};
        mvec[7] = '{1'b0, 2'b00, 3'b100, 3'b100, 1'b0};
        mvec[8] = '{1'b0, 2'b00, 3'b111, 3'b001, 1'b1};

        svec[0] = '{1, ST_RESET};
        svec[1] = '{3, ST_RESET};
        svec[2] = '{4, ST_RESET};
        svec[3] = '{5, ST_BOOT};
        svec[4] = '{6, ST_RUN};
        svec[5] = '{9, ST_RUN};

        rst_n = 1'b0; start = 1'b0; boot_addr = '0; master_core = 3'b001;
        safe_mode = 1'b0; safe_cfg = 2'b00; crit = 1'b0; sleep = '0; dbg = '0;

        wait_until(2);
        push_st(cyc, "reset_hold", ST_IDLE, 3'b000, 32'h0, 1'b0);
        rst_n = 1'b1;
        wait_until(4);
        push_st(cyc, "reset_idle", ST_IDLE, 3'b000, 32'h0, 1'b0);

        // TMR launch with default hold
        wait_until(5);
        c = cyc;
        safe_mode = 1'b1; safe_cfg = 2'b00; boot_addr = 32'h0000_1000; start = 1'b1;
        push_st(c, "tmr_c0", ST_IDLE, 3'b000, 32'h0, 1'b0);
        for (int i = 0; i < 6; i++)
            push_st(c + svec[i].off, $sformatf("tmr_off%0d", svec[i].off), svec[i].st,
                    3'b111, 32'h0000_1000, 1'b0);
        wait_until(c + 10);

        // Abort from RUN
        start = 1'b0;
        push_st(cyc + 1, "abort", ST_IDLE, 3'b111, 32'h0000_1000, 1'b0);
        wait_until(cyc + 2);

        // DMR completion; hart 2 awake and in debug, both outside the mask
        c = cyc;
        safe_cfg = 2'b01; boot_addr = 32'h0000_2000; dbg = 3'b100; start = 1'b1;
        push_st(c + 13, "dmr_pre_end", ST_RUN, 3'b011, 32'h0000_2000, 1'b0);
        push_st(c + 14, "dmr_end", ST_DONE, 3'b011, 32'h0000_2000, 1'b0);
        wait_until(c + 6);
        sleep = 3'b011;
        wait_until(c + 15);
        start = 1'b0;
        push_st(c + 16, "done_start_low", ST_DONE, 3'b011, 32'h0000_2000, 1'b0);
        push_st(c + 18, "done_hold", ST_DONE, 3'b011, 32'h0000_2000, 1'b0);
        wait_until(c + 19);

        // Relaunch from DONE, then filter broken by one awake cycle
        c = cyc;
        safe_cfg = 2'b00; boot_addr = 32'h0000_3000; dbg = 3'b000; start = 1'b1;
        push_st(c, "relaunch_c0", ST_DONE, 3'b011, 32'h0000_2000, 1'b0);
        push_st(c + 1, "relaunch_reset", ST_RESET, 3'b111, 32'h0000_3000, 1'b0);
        push_st(c + 14, "filter_broken", ST_RUN, 3'b111, 32'h0000_3000, 1'b0);
        push_st(c + 21, "filter_pre_end", ST_RUN, 3'b111, 32'h0000_3000, 1'b0);
        push_st(c + 22, "filter_end", ST_DONE, 3'b111, 32'h0000_3000, 1'b0);
        wait_until(c + 6);
        sleep = 3'b111;
        wait_until(c + 13);
        sleep = 3'b110;
        wait_until(c + 14);
        sleep = 3'b111;
        wait_until(c + 23);
        start = 1'b0;
        wait_until(c + 24);

        // Debug mode, then critical section, each holding off completion
        c = cyc;
        boot_addr = 32'h0000_4000; dbg = 3'b001; start = 1'b1;
        push_st(c, "block_c0", ST_DONE, 3'b111, 32'h0000_3000, 1'b0);
        push_st(c + 19, "dbg_blocks", ST_RUN, 3'b111, 32'h0000_4000, 1'b0);
        push_st(c + 35, "crit_blocks", ST_RUN, 3'b111, 32'h0000_4000, 1'b0);
        push_st(c + 43, "unblock_pre_end", ST_RUN, 3'b111, 32'h0000_4000, 1'b0);
        push_st(c + 44, "unblock_end", ST_DONE, 3'b111, 32'h0000_4000, 1'b0);
        wait_until(c + 20);
        dbg = 3'b000; crit = 1'b1;
        wait_until(c + 36);
        crit = 1'b0;
        wait_until(c + 45);

        // Active-mask / cfg_err table, checked at BOOT of each launch
        sleep = 3'b000;
        for (int i = 0; i < 9; i++) begin
            start = 1'b0;
            wait_until(cyc + 1);
            c = cyc;
            a = 32'h0000_0100 * (i + 1);
            safe_mode = mvec[i].sm; safe_cfg = mvec[i].cfg; master_core = mvec[i].master;
            boot_addr = a; start = 1'b1;
            push_st(c + 5, $sformatf("mask%0d", i), ST_BOOT, mvec[i].exp_mask, a, mvec[i].exp_err);
            wait_until(c + 6);
        end

        // Reset asserted during RESET
        start = 1'b0;
        wait_until(cyc + 1);
        c = cyc;
        safe_mode = 1'b1; safe_cfg = 2'b00; boot_addr = 32'h0000_5000; start = 1'b1;
        push_st(c + 2, "midrun_in_reset", ST_RESET, 3'b111, 32'h0000_5000, 1'b0);
        wait_until(c + 2);
        rst_n = 1'b0;
        push_st(c + 3, "midrun_rst", ST_IDLE, 3'b000, 32'h0, 1'b0);
        wait_until(c + 3);
        rst_n = 1'b1; start = 1'b0;
        push_st(c + 4, "midrun_after", ST_IDLE, 3'b000, 32'h0, 1'b0);
        wait_until(c + 6);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
